// File: rtl/video_timing_if.sv
// Raster timing bus between the timing generator and its consumers; csync exists only with VIDEO_TIMING_CSYNC_EN.
interface video_timing_if;
  logic       ce5;
  logic       irq_ack;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       irq;
`ifdef VIDEO_TIMING_CSYNC_EN
  logic       csync;
`endif

  modport master (
    input  ce5, irq_ack,
`ifdef VIDEO_TIMING_CSYNC_EN
    output csync,
`endif
    output hcount, vcount, hblank, vblank, hsync, vsync, frame_start, irq
  );

  modport slave (
    output ce5, irq_ack,
`ifdef VIDEO_TIMING_CSYNC_EN
    input  csync,
`endif
    input  hcount, vcount, hblank, vblank, hsync, vsync, frame_start, irq
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: counters, blank/sync flags (zero skew to counts), frame strobe, line-rate irq.
// Advances only on ce5, no backpressure; VIDEO_TIMING_CSYNC_EN adds registered csync = hsync ^ vsync.
module video_timing #(
  parameter int H_TOTAL      = 320,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 272,
  parameter int H_SYNC_LEN   = 24,
  parameter int V_TOTAL      = 256,
  parameter int V_ACTIVE     = 232,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_LEN   = 3,
  parameter int IRQ_SHIFT    = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  video_timing_if.master vt
);

  // 10-bit constants so sync end cannot overflow the compare
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_START + V_SYNC_LEN);

  logic [8:0] hcount_q;
  logic [7:0] vcount_q;
  logic       hblank_q, vblank_q, hsync_q, vsync_q, frame_start_q, irq_q;

  logic       h_wrap, v_last, irq_set;
  logic [8:0] h_nxt;
  logic [7:0] v_nxt;
  logic [9:0] h_nxt_w, v_nxt_w;
  logic       hblank_n, vblank_n, hsync_n, vsync_n;

  always_comb begin
    h_wrap   = ({1'b0, hcount_q} == HT - 10'd1);
    v_last   = ({2'b0, vcount_q} == VT - 10'd1);
    h_nxt    = h_wrap ? 9'd0 : hcount_q + 9'd1;
    v_nxt    = !h_wrap ? vcount_q : (v_last ? 8'd0 : vcount_q + 8'd1);
    h_nxt_w  = {1'b0, h_nxt};
    v_nxt_w  = {2'b0, v_nxt};
    hblank_n = (h_nxt_w >= HA);
    hsync_n  = (h_nxt_w >= HSS) && (h_nxt_w < HSE);
    vblank_n = (v_nxt_w >= VA);
    vsync_n  = (v_nxt_w >= VSS) && (v_nxt_w < VSE);
    irq_set  = vt.ce5 && h_wrap && (v_nxt[IRQ_SHIFT-1:0] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      frame_start_q <= vt.ce5 && h_wrap && v_last;
      if (vt.ce5) begin
        hcount_q <= h_nxt;
        vcount_q <= v_nxt;
        hblank_q <= hblank_n;
        vblank_q <= vblank_n;
        hsync_q  <= hsync_n;
        vsync_q  <= vsync_n;
      end
      // a set on the same edge as an ack takes priority
      if (irq_set)
        irq_q <= 1'b1;
      else if (vt.irq_ack)
        irq_q <= 1'b0;
    end
  end

`ifdef VIDEO_TIMING_CSYNC_EN
  logic csync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      csync_q <= 1'b0;
    else if (vt.ce5)
      csync_q <= hsync_n ^ vsync_n;
  end

  assign vt.csync = csync_q;
`endif

  assign vt.hcount      = hcount_q;
  assign vt.vcount      = vcount_q;
  assign vt.hblank      = hblank_q;
  assign vt.vblank      = vblank_q;
  assign vt.hsync       = hsync_q;
  assign vt.vsync       = vsync_q;
  assign vt.frame_start = frame_start_q;
  assign vt.irq         = irq_q;

endmodule
